// File: rtl/vliw_bypass_net.sv
// N-lane operand bypass network with E->M and M->W result pipeline registers and a
// bundle-wide load-use stall. Define VLIW_FWD_PERF_EN to add saturating forwarding counters.
module vliw_bypass_net #(
  parameter int NLANES = 4,
  parameter int XLEN   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     StallE,
  input  logic                     StallM,
  input  logic                     StallW,
  input  logic                     FlushM,
  input  logic                     FlushW,
  input  logic [NLANES*5-1:0]      Rs1D,
  input  logic [NLANES*5-1:0]      Rs2D,
  input  logic [NLANES*5-1:0]      Rs1E,
  input  logic [NLANES*5-1:0]      Rs2E,
  input  logic [NLANES*5-1:0]      RdE,
  input  logic [NLANES-1:0]        RegWriteE,
  input  logic [NLANES-1:0]        IsLoadE,
  input  logic [NLANES*XLEN-1:0]   ResultE,
  input  logic [NLANES*XLEN-1:0]   LoadDataW,
  input  logic [NLANES*XLEN-1:0]   RegSrcAE,
  input  logic [NLANES*XLEN-1:0]   RegSrcBE,
  output logic [NLANES*XLEN-1:0]   ForwardedSrcAE,
  output logic [NLANES*XLEN-1:0]   ForwardedSrcBE,
  output logic [NLANES*2-1:0]      FwdSelAE,
  output logic [NLANES*2-1:0]      FwdSelBE,
  output logic                     LoadUseStallD,
  output logic [NLANES*5-1:0]      RdM,
  output logic [NLANES*5-1:0]      RdW,
  output logic [NLANES-1:0]        RegWriteM,
  output logic [NLANES-1:0]        RegWriteW,
  output logic [NLANES*XLEN-1:0]   ResultM,
  output logic [NLANES*XLEN-1:0]   ResultW,
  output logic [31:0]              FwdCountM,
  output logic [31:0]              FwdCountW,
  output logic [31:0]              LoadUseCount
);

  logic [NLANES*5-1:0]    rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic [NLANES-1:0]      regwrite_m_q, regwrite_m_d, regwrite_w_q, regwrite_w_d;
  logic [NLANES-1:0]      isload_m_q, isload_m_d, isload_w_q, isload_w_d;
  logic [NLANES*XLEN-1:0] result_m_q, result_m_d, result_w_q, result_w_d;

  // Stage registers: a stalled stage holds even when flushed.
  always_comb begin
    rd_m_d       = rd_m_q;
    regwrite_m_d = regwrite_m_q;
    isload_m_d   = isload_m_q;
    result_m_d   = result_m_q;
    rd_w_d       = rd_w_q;
    regwrite_w_d = regwrite_w_q;
    isload_w_d   = isload_w_q;
    result_w_d   = result_w_q;
    if (!StallM) begin
      if (FlushM) begin
        rd_m_d       = '0;
        regwrite_m_d = '0;
        isload_m_d   = '0;
        result_m_d   = '0;
      end else begin
        rd_m_d       = RdE;
        regwrite_m_d = RegWriteE;
        isload_m_d   = IsLoadE;
        result_m_d   = ResultE;
      end
    end
    if (!StallW) begin
      if (FlushW) begin
        rd_w_d       = '0;
        regwrite_w_d = '0;
        isload_w_d   = '0;
        result_w_d   = '0;
      end else begin
        rd_w_d       = rd_m_q;
        regwrite_w_d = regwrite_m_q;
        isload_w_d   = isload_m_q;
        result_w_d   = result_m_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_m_q       <= '0;
      regwrite_m_q <= '0;
      isload_m_q   <= '0;
      result_m_q   <= '0;
      rd_w_q       <= '0;
      regwrite_w_q <= '0;
      isload_w_q   <= '0;
      result_w_q   <= '0;
    end else begin
      rd_m_q       <= rd_m_d;
      regwrite_m_q <= regwrite_m_d;
      isload_m_q   <= isload_m_d;
      result_m_q   <= result_m_d;
      rd_w_q       <= rd_w_d;
      regwrite_w_q <= regwrite_w_d;
      isload_w_q   <= isload_w_d;
      result_w_q   <= result_w_d;
    end
  end

  assign RdM       = rd_m_q;
  assign RdW       = rd_w_q;
  assign RegWriteM = regwrite_m_q;
  assign RegWriteW = regwrite_w_q;
  assign ResultM   = result_m_q;

  // Returns {sel, value}. Ascending loops let the highest lane win; M is applied after W to win.
  function automatic logic [XLEN+1:0] pick(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    logic [1:0]      sel;
    logic [XLEN-1:0] val;
    sel = 2'b00;
    val = rf;
    if (rs != 5'd0) begin
      for (int j = 0; j < NLANES; j++) begin
        if (regwrite_w_q[j] && rd_w_q[j*5 +: 5] == rs) begin
          sel = 2'b01;
          val = ResultW[j*XLEN +: XLEN];
        end
      end
      for (int j = 0; j < NLANES; j++) begin
        if (regwrite_m_q[j] && !isload_m_q[j] && rd_m_q[j*5 +: 5] == rs) begin
          sel = 2'b10;
          val = result_m_q[j*XLEN +: XLEN];
        end
      end
    end
    return {sel, val};
  endfunction

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    logic [XLEN+1:0] pick_a, pick_b;

    assign ResultW[gi*XLEN +: XLEN] = isload_w_q[gi] ? LoadDataW[gi*XLEN +: XLEN]
                                                     : result_w_q[gi*XLEN +: XLEN];

    always_comb begin
      pick_a = pick(Rs1E[gi*5 +: 5], RegSrcAE[gi*XLEN +: XLEN]);
      pick_b = pick(Rs2E[gi*5 +: 5], RegSrcBE[gi*XLEN +: XLEN]);
    end

    assign FwdSelAE[gi*2 +: 2]          = pick_a[XLEN +: 2];
    assign ForwardedSrcAE[gi*XLEN +: XLEN] = pick_a[XLEN-1:0];
    assign FwdSelBE[gi*2 +: 2]          = pick_b[XLEN +: 2];
    assign ForwardedSrcBE[gi*XLEN +: XLEN] = pick_b[XLEN-1:0];
  end

  always_comb begin
    LoadUseStallD = 1'b0;
    for (int j = 0; j < NLANES; j++) begin
      for (int i = 0; i < NLANES; i++) begin
        if (IsLoadE[j] && RegWriteE[j] && RdE[j*5 +: 5] != 5'd0 &&
            (Rs1D[i*5 +: 5] == RdE[j*5 +: 5] || Rs2D[i*5 +: 5] == RdE[j*5 +: 5]))
          LoadUseStallD = 1'b1;
      end
    end
  end

`ifdef VLIW_FWD_PERF_EN
  logic [31:0] fwd_cnt_m_q, fwd_cnt_m_d, fwd_cnt_w_q, fwd_cnt_w_d, lu_cnt_q, lu_cnt_d;
  logic [4:0]  inc_m, inc_w;
  logic [32:0] sum_m, sum_w;

  always_comb begin
    inc_m = '0;
    inc_w = '0;
    for (int i = 0; i < NLANES; i++) begin
      inc_m = inc_m + 5'(FwdSelAE[i*2 +: 2] == 2'b10) + 5'(FwdSelBE[i*2 +: 2] == 2'b10);
      inc_w = inc_w + 5'(FwdSelAE[i*2 +: 2] == 2'b01) + 5'(FwdSelBE[i*2 +: 2] == 2'b01);
    end
    sum_m       = {1'b0, fwd_cnt_m_q} + 33'(inc_m);
    sum_w       = {1'b0, fwd_cnt_w_q} + 33'(inc_w);
    fwd_cnt_m_d = sum_m[32] ? 32'hFFFF_FFFF : sum_m[31:0];
    fwd_cnt_w_d = sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0];
    lu_cnt_d    = lu_cnt_q;
    if (LoadUseStallD && !StallE && lu_cnt_q != 32'hFFFF_FFFF)
      lu_cnt_d = lu_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt_m_q <= '0;
      fwd_cnt_w_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      fwd_cnt_m_q <= fwd_cnt_m_d;
      fwd_cnt_w_q <= fwd_cnt_w_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign FwdCountM    = fwd_cnt_m_q;
  assign FwdCountW    = fwd_cnt_w_q;
  assign LoadUseCount = lu_cnt_q;
`else
  logic unused_stall_e;
  assign unused_stall_e = StallE;
  assign FwdCountM    = '0;
  assign FwdCountW    = '0;
  assign LoadUseCount = '0;
`endif

endmodule

// File: doc/vliw_bypass_net.md
# vliw_bypass_net

Parametrised N-lane operand bypass network and load-use hazard detector for the VLIW integer pipeline. It replaces the fixed four-instance, point-to-point forwarding wiring between IEU instances with one shared block. The block owns the E→M and M→W destination/result pipeline registers for every lane. It resolves Execute-stage operand forwarding across all lanes with defined priority, and raises the Decode-stage load-use stall for the whole bundle.

## Interface
Parameters:
- NLANES, 4, number of issue lanes (1..8); lane index = program order within bundle
- XLEN, 64, datapath width

Ports (per-lane buses packed, lane i at slice i):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- StallE, StallM, StallW  in  1 each  bundle-wide stage stalls from hazard unit
- FlushM, FlushW  in  1 each  bundle-wide stage flushes
- Rs1D, Rs2D  in  NLANES×5  Decode source registers
- Rs1E, Rs2E  in  NLANES×5  Execute source registers
- RdE  in  NLANES×5  Execute destination
- RegWriteE  in  NLANES  lane writes integer regfile
- IsLoadE  in  NLANES  lane result comes from LSU (valid only in W)
- ResultE  in  NLANES×XLEN  Execute-stage result (ALU/IEUAdr path)
- LoadDataW  in  NLANES×XLEN  LSU read data in Writeback
- RegSrcAE, RegSrcBE  in  NLANES×XLEN  regfile operands already registered into E
- ForwardedSrcAE, ForwardedSrcBE  out  NLANES×XLEN  bypassed operands
- FwdSelAE, FwdSelBE  out  NLANES×2  00 regfile, 01 W, 10 M
- LoadUseStallD  out  1  stall Decode (and Fetch) one cycle
- RdM, RdW  out  NLANES×5; RegWriteM, RegWriteW  out  NLANES
- ResultM, ResultW  out  NLANES×XLEN  (ResultW drives regfile write ports)
- FwdCountM, FwdCountW, LoadUseCount  out  32 each  (only with VLIW_FWD_PERF_EN)

## Operation
- Pipeline registers per lane: E→M {Rd, RegWrite, IsLoad, Result}; M→W {Rd, RegWrite, IsLoad, Result}. ResultW = IsLoadW ? LoadDataW : registered result.
- Register update matches the codebase clear-enable flop: a stage register loads only when its stall is low. If loading and its flush is high, it loads zeros; otherwise it loads its inputs. A stalled stage holds even if flushed.
- Forward match for operand X of lane i against producer j in stage S: RegWriteS[j] & RdS[j]==RsXE[i] & RsXE[i]!=0. An M-stage match additionally requires !IsLoadM[j].
- Priority: any M match beats any W match (younger bundle). Within one stage, the highest matching lane index wins (last writer in bundle). With no match, the regfile value is used and FwdSel=00.
- x0 never forwarded, even if a producer has RegWrite with Rd=0.
- Intra-bundle (same E-stage) RAW is not forwarded; the compiler guarantees independence, and the bench asserts no lane reads an Rd written by a lower lane in the same bundle.
- LoadUseStallD = OR over i,j of IsLoadE[j] & RegWriteE[j] & RdE[j]!=0 & (Rs1D[i]==RdE[j] | Rs2D[i]==RdE[j]). It is purely combinational; the hazard unit inserts an E bubble, so the consumer reaches E with the load in W.
- A consumer in E matching only a load in M is illegal. A bench assertion checks this; the block falls back to W/regfile.

## Timing
- Forwarding and LoadUseStallD: combinational, same cycle as inputs.
- Result latency: ResultE appears on ResultM one edge later and on ResultW two edges later (absent stalls).
- Reset (async): all pipeline registers, RdM/W, RegWriteM/W, ResultM and registered W result go to 0. FwdSel outputs are 00 and LoadUseStallD is 0 with zero inputs. Perf counters are 0.
- Reset asserted mid-bundle drops all in-flight writes; nothing is forwarded on the first cycle after release.
- StallM with StallW low: the W register still loads a copy of M. The hazard unit never issues this combination, and the bench asserts against it.

## Configuration
- VLIW_FWD_PERF_EN defined: three 32-bit saturating counters, cleared by reset.
  - FwdCountM increments by the number of operands selecting M that cycle.
  - FwdCountW does the same for W.
  - LoadUseCount increments each cycle LoadUseStallD=1 and StallE=0.
  - All three freeze at 0xFFFFFFFF.
- Undefined: counter ports are tied to 0, and no counter flops exist.

## Test plan
- NLANES=4. Lane 2 in M writes x5=0xAA and lane 0 in W writes x5=0xBB; lane 1 in E reads Rs1=x5 → FwdSelAE[1]=10, ForwardedSrcAE[1]=0xAA.
- Lanes 0 and 3 in M both write x7 (0x11, 0x33); lane 0 in E reads x7 → value 0x33 (highest lane wins).
- Lane 1 in E is a load writing x9; lane 2 in D reads Rs2=x9 → LoadUseStallD=1. After the bubble, lane 2 in E gets LoadDataW[1]=0x1234 with FwdSel=01.
- Producer writes x0=0xFF in M; consumer reads x0 → FwdSel=00 and RegSrc value is passed through.
- FlushM=1, StallM=0 with RegWriteE=1111 → RegWriteM=0000 next cycle. Repeat with StallM=1 → RegWriteM holds its prior value.
- Perf build: two M-forwards per cycle for 3 cycles → FwdCountM=6. Preload near max → saturates at 0xFFFFFFFF. Assert reset mid-run → all counters 0 asynchronously.
